// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one 1-bit subtract cell plus a borrow
// flop is reused across a WIDTH-bit word, LSB first, one bit per clock.
// Start/busy/done handshake; results hold until the next op completes.

// 1-bit full subtractor: d = a - b - br_in, br_out = borrow to next bit.
module sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);
  // Pure combinational difference and borrow.
  always_comb begin
    d_o  = a_i ^ b_i ^ br_i;
    br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
  end
endmodule

module serial_sub_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borr_q, borr_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d, cell_br;
  logic             last_bit;

  // The single shared subtract cell always looks at the current LSBs.
  sub_cell u_cell (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .br_i (br_q),
    .d_o  (cell_d),
    .br_o (cell_br)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state: sequencing, operand shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    borr_d  = borr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Result bits enter from the MSB side so the LSB ends at bit 0.
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        br_d   = cell_br;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d  = res_d;
          borr_d  = cell_br;
          zero_d  = (res_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Single-cycle completion; any start here is dropped.
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over everything, including mid-SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      borr_q  <= borr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign borr = borr_q;
  assign zero = zero_q;

endmodule
